mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a simple dual-port RAM (one read + one write per cycle),
// with a built-in sequential memory-clear engine that fills every location with a fixed value.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_gnt,
    output logic                  b_gnt,
    output logic                  a_rvalid,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [ADDR_WIDTH-1:0] mem_rdaddress,
    output logic [ADDR_WIDTH-1:0] mem_wraddress,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    typedef enum logic [0:0] {SERVE = 1'b0, CLEAR = 1'b1} state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX   = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_r, state_nxt_s;
    logic                    prio_r, prio_nxt_s;
    logic [ADDR_WIDTH-1:0]   cnt_r, cnt_nxt_s;
    logic [DATA_WIDTH-1:0]   clr_val_r, clr_val_nxt_s;
    logic                    rd_pend_r, rd_own_r;

    logic                    a_rdreq_s, b_rdreq_s, a_wrreq_s, b_wrreq_s;
    logic                    a_rd_s, b_rd_s, a_wr_s, b_wr_s;
    logic                    rden_s, wren_s, busy_s, done_s;
    logic [ADDR_WIDTH-1:0]   rdaddr_s, wraddr_s;
    logic [DATA_WIDTH-1:0]   wdata_s;

    assign a_rdreq_s = a_req & ~a_we;
    assign b_rdreq_s = b_req & ~b_we;
    assign a_wrreq_s = a_req &  a_we;
    assign b_wrreq_s = b_req &  b_we;

    // Next-state, arbitration and RAM-port decode.
    always_comb begin
        state_nxt_s   = state_r;
        prio_nxt_s    = prio_r;
        cnt_nxt_s     = cnt_r;
        clr_val_nxt_s = clr_val_r;
        a_rd_s        = 1'b0;
        b_rd_s        = 1'b0;
        a_wr_s        = 1'b0;
        b_wr_s        = 1'b0;
        rden_s        = 1'b0;
        wren_s        = 1'b0;
        rdaddr_s      = ADDR_ZERO;
        wraddr_s      = ADDR_ZERO;
        wdata_s       = DATA_ZERO;
        busy_s        = 1'b0;
        done_s        = 1'b0;
        case (state_r)
            SERVE: begin
                if (clr_start) begin
                    state_nxt_s   = CLEAR;
                    cnt_nxt_s     = ADDR_ZERO;
                    clr_val_nxt_s = clr_value;
                end else begin
                    // Requests of the same type collide; different types share the cycle.
                    if (a_rdreq_s && b_rdreq_s) begin
                        a_rd_s     = ~prio_r;
                        b_rd_s     = prio_r;
                        prio_nxt_s = ~prio_r;
                    end else begin
                        a_rd_s = a_rdreq_s;
                        b_rd_s = b_rdreq_s;
                    end
                    if (a_wrreq_s && b_wrreq_s) begin
                        a_wr_s     = ~prio_r;
                        b_wr_s     = prio_r;
                        prio_nxt_s = ~prio_r;
                    end else begin
                        a_wr_s = a_wrreq_s;
                        b_wr_s = b_wrreq_s;
                    end
                    rden_s = a_rd_s | b_rd_s;
                    wren_s = a_wr_s | b_wr_s;
                    if (a_rd_s) begin
                        rdaddr_s = a_addr;
                    end else if (b_rd_s) begin
                        rdaddr_s = b_addr;
                    end else begin
                        rdaddr_s = ADDR_ZERO;
                    end
                    if (a_wr_s) begin
                        wraddr_s = a_addr;
                        wdata_s  = a_wdata;
                    end else if (b_wr_s) begin
                        wraddr_s = b_addr;
                        wdata_s  = b_wdata;
                    end else begin
                        wraddr_s = ADDR_ZERO;
                        wdata_s  = DATA_ZERO;
                    end
                end
            end
            CLEAR: begin
                busy_s   = 1'b1;
                wren_s   = 1'b1;
                wraddr_s = cnt_r;
                wdata_s  = clr_val_r;
                if (cnt_r == CNT_MAX) begin
                    done_s      = 1'b1;
                    cnt_nxt_s   = ADDR_ZERO;
                    state_nxt_s = SERVE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = SERVE;
            end
        endcase
    end

    // State, priority, clear engine and read-owner registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= SERVE;
            prio_r    <= 1'b0;
            cnt_r     <= ADDR_ZERO;
            clr_val_r <= DATA_ZERO;
            rd_pend_r <= 1'b0;
            rd_own_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            prio_r    <= prio_nxt_s;
            cnt_r     <= cnt_nxt_s;
            clr_val_r <= clr_val_nxt_s;
            rd_pend_r <= a_rd_s | b_rd_s;
            rd_own_r  <= b_rd_s;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign a_gnt         = reset_n & (a_rd_s | a_wr_s);
    assign b_gnt         = reset_n & (b_rd_s | b_wr_s);
    assign a_rvalid      = reset_n & rd_pend_r & ~rd_own_r;
    assign b_rvalid      = reset_n & rd_pend_r &  rd_own_r;
    assign rdata         = reset_n ? mem_q : DATA_ZERO;
    assign clr_busy      = reset_n & busy_s;
    assign clr_done      = reset_n & done_s;
    assign mem_rden      = reset_n & rden_s;
    assign mem_wren      = reset_n & wren_s;
    assign mem_rdaddress = reset_n ? rdaddr_s : ADDR_ZERO;
    assign mem_wraddress = reset_n ? wraddr_s : ADDR_ZERO;
    assign mem_data      = reset_n ? wdata_s  : DATA_ZERO;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural RAM, reference memory and a
// read scoreboard checked every cycle against rvalid/rdata.
module tb_mem_port_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] rdata;
    logic          clr_start = 1'b0;
    logic [DW-1:0] clr_value = '0;
    logic          clr_busy, clr_done, mem_rden, mem_wren;
    logic [AW-1:0] mem_rdaddress, mem_wraddress;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_q = '0;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_rdaddress(mem_rdaddress), .mem_wraddress(mem_wraddress),
        .mem_data(mem_data), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural RAM: registered read, write visible to the next cycle's read.
    logic [DW-1:0] ram [DEPTH];
    logic          ram_init = 1'b0;
    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
            ram_init <= 1'b1;
        end else begin
            if (mem_wren) ram[mem_wraddress] <= mem_data;
            if (mem_rden) mem_q <= ram[mem_rdaddress];
        end
    end

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
        int            due;
    } rd_t;
    rd_t           sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          exp_prio = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0; clr_start = 1'b0;
    endtask

    task automatic push_rd(input logic owner, input logic [AW-1:0] addr);
        rd_t e;
        e.owner = owner;
        e.data  = ref_mem[addr];
        e.due   = cyc + 1;
        sb.push_back(e);
    endtask

    // Scoreboard: every cycle out of reset, rvalid/rdata must match the head entry due now.
    always @(negedge clock) begin
        logic          ea, eb;
        logic [DW-1:0] ed;
        rd_t           e;
        if (reset_n) begin
            ea = 1'b0; eb = 1'b0; ed = '0;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                ea = (e.due == cyc) && !e.owner;
                eb = (e.due == cyc) &&  e.owner;
                ed = e.data;
            end
            n_checks++;
            if ({a_rvalid, b_rvalid} !== {ea, eb}) begin
                n_fail++;
                $display("FAIL rvalid @cyc %0d: got a=%b b=%b expected a=%b b=%b", cyc, a_rvalid, b_rvalid, ea, eb);
            end
            if (ea || eb) begin
                n_checks++;
                if (rdata !== ed) begin
                    n_fail++;
                    $display("FAIL rdata @cyc %0d: got %0h expected %0h", cyc, rdata, ed);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h3;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'h4; b_wdata = 8'hA5;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, clr_done, mem_rden, mem_wren} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, clr_done, mem_rden, mem_wren});
        end
        n_checks++;
        if ({mem_rdaddress, mem_wraddress, mem_data} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_bus: got %0h expected 0", {mem_rdaddress, mem_wraddress, mem_data});
        end
        idle();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'hA; a_wdata = 8'h5A;
        @(negedge clock);
        n_checks++;
        if ({a_gnt, b_gnt, mem_wren, mem_rden, mem_wraddress, mem_data} !== {4'b1010, 4'hA, 8'h5A}) begin
            n_fail++;
            $display("FAIL write_grant: got %0h expected %0h",
                     {a_gnt, b_gnt, mem_wren, mem_rden, mem_wraddress, mem_data}, {4'b1010, 4'hA, 8'h5A});
        end
        ref_mem[4'hA] = 8'h5A;
        step();
        a_we = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({a_gnt, b_gnt, mem_rden, mem_wren, mem_rdaddress} !== {4'b1010, 4'hA}) begin
            n_fail++;
            $display("FAIL read_grant: got %0h expected %0h",
                     {a_gnt, b_gnt, mem_rden, mem_wren, mem_rdaddress}, {4'b1010, 4'hA});
        end
        push_rd(1'b0, 4'hA);
        step();
        idle();
        step();
    endtask

    task automatic test_read_write_parallel();
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h3;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'h4; b_wdata = 8'h33;
        @(negedge clock);
        n_checks++;
        if ({a_gnt, b_gnt, mem_rden, mem_wren, mem_rdaddress, mem_wraddress, mem_data} !==
            {4'b1111, 4'h3, 4'h4, 8'h33}) begin
            n_fail++;
            $display("FAIL rd_wr_parallel: got %0h expected %0h",
                     {a_gnt, b_gnt, mem_rden, mem_wren, mem_rdaddress, mem_wraddress, mem_data},
                     {4'b1111, 4'h3, 4'h4, 8'h33});
        end
        push_rd(1'b0, 4'h3);
        ref_mem[4'h4] = 8'h33;
        step();
        a_req = 1'b0;
        b_we = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({a_gnt, b_gnt, mem_rden, mem_rdaddress} !== {3'b011, 4'h4}) begin
            n_fail++;
            $display("FAIL lone_b_read: got %0h expected %0h", {a_gnt, b_gnt, mem_rden, mem_rdaddress}, {3'b011, 4'h4});
        end
        push_rd(1'b1, 4'h4);
        step();
        idle();
        step();
    endtask

    task automatic test_conflicts();
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        for (int i = 0; i < 4; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = 4'hA;
            b_req = 1'b1; b_we = 1'b0; b_addr = 4'h4;
            @(negedge clock);
            wa = exp_prio ? 4'h4 : 4'hA;
            n_checks++;
            if ({a_gnt, b_gnt, mem_rdaddress} !== {~exp_prio, exp_prio, wa}) begin
                n_fail++;
                $display("FAIL rd_conflict %0d: got %0h expected %0h", i, {a_gnt, b_gnt, mem_rdaddress}, {~exp_prio, exp_prio, wa});
            end
            push_rd(exp_prio, wa);
            exp_prio = ~exp_prio;
            step();
        end
        for (int i = 0; i < 2; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = 4'h6; a_wdata = 8'h60 + 8'(i);
            b_req = 1'b1; b_we = 1'b1; b_addr = 4'h7; b_wdata = 8'h70 + 8'(i);
            @(negedge clock);
            wa = exp_prio ? 4'h7 : 4'h6;
            wd = exp_prio ? b_wdata : a_wdata;
            n_checks++;
            if ({a_gnt, b_gnt, mem_wren, mem_wraddress, mem_data} !== {~exp_prio, exp_prio, 1'b1, wa, wd}) begin
                n_fail++;
                $display("FAIL wr_conflict %0d: got %0h expected %0h", i,
                         {a_gnt, b_gnt, mem_wren, mem_wraddress, mem_data}, {~exp_prio, exp_prio, 1'b1, wa, wd});
            end
            ref_mem[wa] = wd;
            exp_prio = ~exp_prio;
            step();
        end
        idle();
        a_req = 1'b1; a_addr = 4'h6;
        @(negedge clock);
        push_rd(1'b0, 4'h6);
        step();
        a_req = 1'b0; b_req = 1'b1; b_addr = 4'h7;
        @(negedge clock);
        push_rd(1'b1, 4'h7);
        step();
        idle();
        step();
    endtask

    task automatic test_clear();
        int done_cnt = 0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'hA;
        @(negedge clock);
        push_rd(1'b0, 4'hA);
        step();
        clr_start = 1'b1; clr_value = 8'hFF; a_addr = 4'h5;
        @(negedge clock);
        n_checks++;
        if ({a_gnt, mem_rden, mem_wren, clr_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL clr_start_cycle: got %b expected 0000", {a_gnt, mem_rden, mem_wren, clr_busy});
        end
        step();
        for (int i = 0; i < DEPTH; i++) begin
            clr_start = (i == 5);
            clr_value = (i == 5) ? 8'h11 : 8'h00;
            @(negedge clock);
            n_checks++;
            if ({clr_busy, a_gnt, b_gnt, mem_rden, mem_wren, mem_wraddress, mem_data, clr_done} !==
                {5'b10001, 4'(i), 8'hFF, (i == DEPTH - 1)}) begin
                n_fail++;
                $display("FAIL clear_cycle %0d: got %0h expected %0h", i,
                         {clr_busy, a_gnt, b_gnt, mem_rden, mem_wren, mem_wraddress, mem_data, clr_done},
                         {5'b10001, 4'(i), 8'hFF, (i == DEPTH - 1)});
            end
            if (clr_done) done_cnt++;
            step();
        end
        clr_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
        @(negedge clock);
        n_checks++;
        if ({clr_busy, clr_done, a_gnt, mem_rdaddress} !== {3'b001, 4'h5}) begin
            n_fail++;
            $display("FAIL clear_exit: got %0h expected %0h", {clr_busy, clr_done, a_gnt, mem_rdaddress}, {3'b001, 4'h5});
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_fail++;
            $display("FAIL clr_done_count: got %0d expected 1", done_cnt);
        end
        push_rd(1'b0, 4'h5);
        step();
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 4'hF;
        @(negedge clock);
        push_rd(1'b1, 4'hF);
        step();
        idle();
        step();
    endtask

    task automatic test_reset_mid_clear();
        clr_start = 1'b1; clr_value = 8'h3C;
        step();
        clr_start = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h9;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            n_checks++;
            if ({clr_busy, mem_wraddress} !== {1'b1, 4'(i)}) begin
                n_fail++;
                $display("FAIL mid_clear %0d: got %0h expected %0h", i, {clr_busy, mem_wraddress}, {1'b1, 4'(i)});
            end
            if (i < 7) step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, clr_done, mem_rden, mem_wren,
             mem_rdaddress, mem_wraddress, mem_data} !== 24'h000000) begin
            n_fail++;
            $display("FAIL reset_abort: got %0h expected 0", {a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, clr_done,
                     mem_rden, mem_wren, mem_rdaddress, mem_wraddress, mem_data});
        end
        exp_prio = 1'b0;
        step();
        reset_n = 1'b1;
        a_we = 1'b1; a_addr = 4'h2; a_wdata = 8'h77;
        @(negedge clock);
        n_checks++;
        if ({clr_busy, a_gnt, mem_wren, mem_wraddress, mem_data} !== {3'b011, 4'h2, 8'h77}) begin
            n_fail++;
            $display("FAIL post_reset_write: got %0h expected %0h",
                     {clr_busy, a_gnt, mem_wren, mem_wraddress, mem_data}, {3'b011, 4'h2, 8'h77});
        end
        ref_mem[4'h2] = 8'h77;
        step();
        a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'h9;
        @(negedge clock);
        n_checks++;
        if ({a_gnt, b_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_reset_prio: got %b expected 10", {a_gnt, b_gnt});
        end
        push_rd(1'b0, 4'h2);
        step();
        a_req = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({a_gnt, b_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_b: got %b expected 01", {a_gnt, b_gnt});
        end
        push_rd(1'b1, 4'h9);
        step();
        idle();
        step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_read_write_parallel();
        test_conflicts();
        test_clear();
        test_reset_mid_clear();
        step();
        @(negedge clock);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
